// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master transfer sequencer.
// Holds the state enum spi_state_t and the DATA_W / DIV_W defaults.
package spi_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DIV_W_DEF  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_STORE,
    S_END
  } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Loadable down-counter giving a half-period tick for the SPI sequencer.
// Ports: clk, rst (async, active-high), load_i/val_i reload, tick_o.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DIV_W-1:0] val_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // tick fires on the last cycle of a val_i+1 cycle window
  assign tick_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_fifo_ctrl.sv
// SPI mode-0 master sequencer between TX/RX byte FIFOs and the SPI pins.
// Ports: FIFO side (tx_*, rx_*), pins (sclk/mosi/miso/cs_n), en/abort, rx_ovf.
// Optional macro SPI_RX_STALL_EN: wait in STORE instead of dropping bytes.
module spi_fifo_ctrl
  import spi_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              abort,
  input  logic [DIV_W-1:0]  clkdiv,
  input  logic              tx_empty,
  input  logic [DATA_W-1:0] tx_q,
  output logic              tx_rd,
  input  logic              rx_full,
  output logic [DATA_W-1:0] rx_d,
  output logic              rx_wr,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_n,
  output logic              busy,
  output logic              rx_ovf,
  input  logic              ovf_clr
);

  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  spi_state_t        state_q, state_d;
  // MSB goes straight to mosi at load, so only the rest is kept
  logic [DATA_W-2:0] txsr_q, txsr_d;
  logic [DATA_W-1:0] rxsr_q, rxsr_d;
  logic [CW-1:0]     bit_q, bit_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              cs_n_q, cs_n_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              ovf_q, ovf_d;
  logic              go;
  logic              tick;
  logic              div_load;
  logic [DIV_W-1:0]  div_val;

`ifdef SPI_RX_STALL_EN
  assign go = en && !tx_empty && !rx_full;
`else
  assign go = en && !tx_empty;
`endif

  // reload on every state change; clkdiv is live only in LOAD
  assign div_load = (state_d != state_q);
  assign div_val  = (state_q == S_LOAD) ? clkdiv : div_q;

  spi_clk_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .load_i (div_load),
    .val_i  (div_val),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    txsr_d  = txsr_q;
    rxsr_d  = rxsr_q;
    bit_d   = bit_q;
    div_d   = div_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ovf_d   = ovf_clr ? 1'b0 : ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (go) state_d = S_LOAD;
      end
      S_LOAD: begin
        txsr_d  = tx_q[DATA_W-2:0];
        mosi_d  = tx_q[DATA_W-1];
        bit_d   = '0;
        div_d   = clkdiv;
        cs_n_d  = 1'b0;
        state_d = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (tick) begin
          sclk_d  = 1'b1;
          rxsr_d  = {rxsr_q[DATA_W-2:0], miso};
          state_d = S_SHIFT_HI;
        end
      end
      S_SHIFT_HI: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (bit_q == LAST) begin
            state_d = S_STORE;
          end else begin
            mosi_d  = txsr_q[DATA_W-2];
            txsr_d  = {txsr_q[DATA_W-3:0], 1'b0};
            bit_d   = bit_q + 1'b1;
            state_d = S_SHIFT_LO;
          end
        end
      end
      S_STORE: begin
`ifdef SPI_RX_STALL_EN
        if (!rx_full)
          state_d = go ? S_LOAD : S_END;
`else
        // set beats a same-cycle clear
        if (rx_full) ovf_d = 1'b1;
        state_d = go ? S_LOAD : S_END;
`endif
      end
      S_END: begin
        if (tick) begin
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d = S_IDLE;
      cs_n_d  = 1'b1;
      sclk_d  = 1'b0;
      mosi_d  = 1'b0;
      ovf_d   = ovf_clr ? 1'b0 : ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      txsr_q  <= '0;
      rxsr_q  <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      txsr_q  <= txsr_d;
      rxsr_q  <= rxsr_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx_rd  = (state_q == S_LOAD) && !abort;
  assign rx_wr  = (state_q == S_STORE) && !rx_full && !abort;
  assign busy   = (state_q != S_IDLE);
  assign rx_d   = rxsr_q;
  assign sclk   = sclk_q;
  assign mosi   = mosi_q;
  assign cs_n   = cs_n_q;
  assign rx_ovf = ovf_q;

endmodule

// File: tb/tb_spi_fifo_ctrl.sv
// Self-checking bench for spi_fifo_ctrl: FIFO + SPI slave models,
// transfer log, and per-scenario checks against byte-level expectations.
module tb_spi_fifo_ctrl;

  logic       clk = 0;
  logic       rst = 1;
  logic       en = 0, abort = 0, ovf_clr = 0, rx_full = 0, loop = 0;
  logic [7:0] clkdiv = 0;
  logic       tx_empty, tx_rd, rx_wr, sclk, mosi, miso, cs_n, busy, rx_ovf;
  logic [7:0] tx_q, rx_d;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  spi_fifo_ctrl #(.DIV_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .abort(abort), .clkdiv(clkdiv),
    .tx_empty(tx_empty), .tx_q(tx_q), .tx_rd(tx_rd), .rx_full(rx_full),
    .rx_d(rx_d), .rx_wr(rx_wr), .sclk(sclk), .mosi(mosi), .miso(miso),
    .cs_n(cs_n), .busy(busy), .rx_ovf(rx_ovf), .ovf_clr(ovf_clr)
  );

  // TX FIFO model (show-ahead)
  logic [7:0] fmem [16];
  int wr_ptr = 0, rd_ptr = 0;
  assign tx_empty = (wr_ptr == rd_ptr);
  assign tx_q = fmem[rd_ptr % 16];
  always @(posedge clk) if (tx_rd) rd_ptr <= rd_ptr + 1;

  // SPI slave model: shifts out slave[] MSB-first, one bit per rising sclk
  logic [7:0] slave [16];
  int nrise = 0, base = 0, rel;
  assign rel = nrise - base;
  assign miso = loop ? mosi : slave[rel[6:3]][3'd7 - rel[2:0]];

  // transfer log
  int cyc = 0, hi_len = 0, last_hi = 0;
  int txrd_cyc[$], rxwr_cyc[$], csrise_cyc[$], rise_cyc[$];
  logic [7:0] rxlog[$];
  logic mosi_bits[$];
  logic sclk_p = 0, cs_p = 1;

  always @(negedge clk) begin
    cyc++;
    if (tx_rd) txrd_cyc.push_back(cyc);
    if (rx_wr) begin rxwr_cyc.push_back(cyc); rxlog.push_back(rx_d); end
    if (cs_n && !cs_p) csrise_cyc.push_back(cyc);
    if (sclk && !sclk_p) begin
      rise_cyc.push_back(cyc);
      mosi_bits.push_back(mosi);
      nrise++;
    end
    if (sclk) hi_len++;
    else if (sclk_p) begin last_hi = hi_len; hi_len = 0; end
    sclk_p = sclk;
    cs_p = cs_n;
  end

  function automatic logic [7:0] mbyte(input int s);
    logic [7:0] b = 0;
    for (int i = 0; i < 8; i++)
      if (s + i < mosi_bits.size()) b = {b[6:0], mosi_bits[s + i]};
    return b;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] b);
    fmem[wr_ptr % 16] = b;
    wr_ptr++;
  endtask

  task automatic wait_done(output bit to);
    to = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (tx_empty && !busy) begin to = 0; break; end
    end
  endtask

  task automatic test_reset();
    logic [15:0] got;
    rst = 1;
    repeat (3) tick();
    got = {tx_rd, rx_wr, rx_d, sclk, mosi, cs_n, busy, rx_ovf};
    nvec++;
    if (got !== 16'h0004) begin
      nerr++; $display("FAIL reset_outputs got=%h exp=0004", got);
    end
    rst = 0;
    tick();
    nvec++;
    if (busy !== 1'b0 || cs_n !== 1'b1) begin
      nerr++; $display("FAIL reset_release busy=%b cs_n=%b", busy, cs_n);
    end
  endtask

  task automatic test_single();
    int t0 = txrd_cyc.size(), r0 = rxwr_cyc.size(), c0 = csrise_cyc.size();
    int m0 = mosi_bits.size(), f0 = rise_cyc.size();
    bit to;
    loop = 1; clkdiv = 0; en = 1;
    push(8'hA5);
    wait_done(to);
    repeat (3) tick();
    nvec++;
    if (to !== 0) begin nerr++; $display("FAIL single_timeout"); end
    nvec++;
    if (mbyte(m0) !== 8'hA5) begin
      nerr++; $display("FAIL single_mosi got=%h exp=a5", mbyte(m0));
    end
    nvec++;
    if (rxwr_cyc.size() - r0 !== 1) begin
      nerr++; $display("FAIL single_rxwr_count got=%0d exp=1", rxwr_cyc.size() - r0);
    end else begin
      nvec++;
      if (rxlog[r0] !== 8'hA5) begin
        nerr++; $display("FAIL single_rx_d got=%h exp=a5", rxlog[r0]);
      end
      nvec++;
      if (txrd_cyc.size() > t0 && rxwr_cyc[r0] - txrd_cyc[t0] !== 17) begin
        nerr++; $display("FAIL single_latency got=%0d exp=17", rxwr_cyc[r0] - txrd_cyc[t0]);
      end
      nvec++;
      if (csrise_cyc.size() <= c0 || csrise_cyc[c0] - rxwr_cyc[r0] !== 2) begin
        nerr++; $display("FAIL single_cs_release got=%0d exp=2", csrise_cyc.size() - c0);
      end
    end
    nvec++;
    if (rise_cyc.size() <= f0 || txrd_cyc.size() <= t0 || rise_cyc[f0] - txrd_cyc[t0] !== 2) begin
      nerr++; $display("FAIL single_first_rise got=%0d exp=2", rise_cyc.size() - f0);
    end
    loop = 0;
  endtask

  task automatic test_back_to_back();
    int t0 = txrd_cyc.size(), r0 = rxwr_cyc.size(), c0 = csrise_cyc.size();
    int m0 = mosi_bits.size();
    logic [7:0] d [3];
    bit to;
    d[0] = 8'h01; d[1] = 8'h80; d[2] = 8'hFF;
    for (int i = 0; i < 3; i++) slave[i] = 8'($urandom);
    base = nrise; clkdiv = 3; en = 1;
    for (int i = 0; i < 3; i++) push(d[i]);
    wait_done(to);
    repeat (6) tick();
    nvec++;
    if (to !== 0) begin nerr++; $display("FAIL b2b_timeout"); end
    nvec++;
    if (txrd_cyc.size() - t0 !== 3 || rxwr_cyc.size() - r0 !== 3) begin
      nerr++; $display("FAIL b2b_counts rd=%0d wr=%0d exp=3/3",
                       txrd_cyc.size() - t0, rxwr_cyc.size() - r0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (rxlog[r0 + i] !== slave[i]) begin
          nerr++; $display("FAIL b2b_rx%0d got=%h exp=%h", i, rxlog[r0 + i], slave[i]);
        end
        nvec++;
        if (mbyte(m0 + 8 * i) !== d[i]) begin
          nerr++; $display("FAIL b2b_mosi%0d got=%h exp=%h", i, mbyte(m0 + 8 * i), d[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        nvec++;
        if (txrd_cyc[t0 + i] - txrd_cyc[t0 + i - 1] !== 66) begin
          nerr++; $display("FAIL b2b_byte_time got=%0d exp=66",
                           txrd_cyc[t0 + i] - txrd_cyc[t0 + i - 1]);
        end
      end
    end
    nvec++;
    if (csrise_cyc.size() - c0 !== 1) begin
      nerr++; $display("FAIL b2b_cs_gap rises=%0d exp=1", csrise_cyc.size() - c0);
    end
    nvec++;
    if (last_hi !== 4) begin
      nerr++; $display("FAIL b2b_half_period got=%0d exp=4", last_hi);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n = $urandom_range(1, 4);
      int h = $urandom_range(1, 3);
      int t0 = txrd_cyc.size(), r0 = rxwr_cyc.size();
      int m0 = mosi_bits.size();
      logic [7:0] d [4];
      bit to;
      for (int i = 0; i < n; i++) begin
        d[i] = 8'($urandom);
        slave[i] = 8'($urandom);
      end
      base = nrise; clkdiv = 8'(h - 1); en = 1;
      for (int i = 0; i < n; i++) push(d[i]);
      wait_done(to);
      repeat (4) tick();
      nvec++;
      if (to !== 0 || rxwr_cyc.size() - r0 !== n || txrd_cyc.size() - t0 !== n) begin
        nerr++; $display("FAIL rand%0d_count wr=%0d exp=%0d", it, rxwr_cyc.size() - r0, n);
      end else begin
        for (int i = 0; i < n; i++) begin
          nvec++;
          if (rxlog[r0 + i] !== slave[i] || mbyte(m0 + 8 * i) !== d[i]
              || rxwr_cyc[r0 + i] - txrd_cyc[t0 + i] !== 16 * h + 1) begin
            nerr++; $display("FAIL rand%0d_byte%0d rx=%h/%h mosi=%h/%h lat=%0d/%0d",
                             it, i, rxlog[r0 + i], slave[i], mbyte(m0 + 8 * i), d[i],
                             rxwr_cyc[r0 + i] - txrd_cyc[t0 + i], 16 * h + 1);
          end
        end
      end
    end
  endtask

`ifdef SPI_RX_STALL_EN
  task automatic test_rx_full();
    int t0 = txrd_cyc.size(), r0 = rxwr_cyc.size();
    bit to;
    slave[0] = 8'($urandom);
    base = nrise; clkdiv = 0; en = 1;
    push(8'h5A);
    for (int i = 0; i < 50 && txrd_cyc.size() == t0; i++) tick();
    rx_full = 1;
    repeat (30) tick();
    nvec++;
    if (rxwr_cyc.size() - r0 !== 0 || cs_n !== 0 || busy !== 1 || rx_ovf !== 0) begin
      nerr++; $display("FAIL stall_wait wr=%0d cs_n=%b busy=%b ovf=%b exp=0/0/1/0",
                       rxwr_cyc.size() - r0, cs_n, busy, rx_ovf);
    end
    rx_full = 0;
    tick(); tick();
    nvec++;
    if (rxwr_cyc.size() - r0 !== 1) begin
      nerr++; $display("FAIL stall_release wr=%0d exp=1", rxwr_cyc.size() - r0);
    end else begin
      nvec++;
      if (rxlog[r0] !== slave[0]) begin
        nerr++; $display("FAIL stall_rx_d got=%h exp=%h", rxlog[r0], slave[0]);
      end
    end
    wait_done(to);
    nvec++;
    if (to !== 0) begin nerr++; $display("FAIL stall_timeout"); end
  endtask
`else
  task automatic test_rx_full();
    int r0 = rxwr_cyc.size(), t0;
    bit to;
    base = nrise; clkdiv = 0; en = 1; rx_full = 1;
    push(8'h33);
    wait_done(to);
    repeat (3) tick();
    nvec++;
    if (to !== 0 || rxwr_cyc.size() - r0 !== 0 || rx_ovf !== 1) begin
      nerr++; $display("FAIL ovf_drop wr=%0d ovf=%b exp=0/1", rxwr_cyc.size() - r0, rx_ovf);
    end
    t0 = txrd_cyc.size();
    push(8'hC3);
    for (int i = 0; i < 50 && txrd_cyc.size() == t0; i++) tick();
    repeat (16) tick();
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    nvec++;
    if (rx_ovf !== 1) begin
      nerr++; $display("FAIL ovf_set_wins got=%b exp=1", rx_ovf);
    end
    wait_done(to);
    ovf_clr = 1;
    tick();
    ovf_clr = 0;
    nvec++;
    if (rx_ovf !== 0) begin
      nerr++; $display("FAIL ovf_clear got=%b exp=0", rx_ovf);
    end
    rx_full = 0;
  endtask
`endif

  task automatic test_abort();
    int r0 = rxwr_cyc.size(), m0;
    bit to;
    base = nrise; clkdiv = 1; en = 1;
    push(8'h3C);
    for (int i = 0; i < 100 && nrise - base < 4; i++) tick();
    abort = 1;
    tick();
    abort = 0;
    nvec++;
    if (cs_n !== 1 || sclk !== 0 || busy !== 0) begin
      nerr++; $display("FAIL abort_state cs_n=%b sclk=%b busy=%b exp=1/0/0", cs_n, sclk, busy);
    end
    repeat (40) tick();
    nvec++;
    if (rxwr_cyc.size() - r0 !== 0) begin
      nerr++; $display("FAIL abort_rxwr got=%0d exp=0", rxwr_cyc.size() - r0);
    end
    slave[0] = 8'($urandom);
    base = nrise; m0 = mosi_bits.size();
    push(8'h96);
    wait_done(to);
    repeat (3) tick();
    nvec++;
    if (to !== 0 || rxwr_cyc.size() - r0 !== 1) begin
      nerr++; $display("FAIL abort_next_count wr=%0d exp=1", rxwr_cyc.size() - r0);
    end else begin
      nvec++;
      if (rxlog[r0] !== slave[0] || mbyte(m0) !== 8'h96) begin
        nerr++; $display("FAIL abort_next_data rx=%h/%h mosi=%h/96",
                         rxlog[r0], slave[0], mbyte(m0));
      end
    end
  endtask

  task automatic test_rst_mid();
    int r0 = rxwr_cyc.size(), m0;
    bit to;
    base = nrise; clkdiv = 2; en = 1;
    push(8'hE7);
    for (int i = 0; i < 200 && sclk !== 1; i++) tick();
    #2 rst = 1;
    #1;
    nvec++;
    if (sclk !== 0 || cs_n !== 1 || busy !== 0) begin
      nerr++; $display("FAIL rst_mid cs_n=%b sclk=%b busy=%b exp=1/0/0", cs_n, sclk, busy);
    end
    tick(); tick();
    rst = 0;
    tick();
    slave[0] = 8'($urandom);
    base = nrise; m0 = mosi_bits.size();
    push(8'h4B);
    wait_done(to);
    repeat (3) tick();
    nvec++;
    if (to !== 0 || rxwr_cyc.size() - r0 !== 1) begin
      nerr++; $display("FAIL rst_restart_count wr=%0d exp=1", rxwr_cyc.size() - r0);
    end else begin
      nvec++;
      if (rxlog[r0] !== slave[0] || mbyte(m0) !== 8'h4B) begin
        nerr++; $display("FAIL rst_restart_data rx=%h/%h mosi=%h/4b",
                         rxlog[r0], slave[0], mbyte(m0));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin fmem[i] = 0; slave[i] = 0; end
    test_reset();
    test_single();
    test_back_to_back();
    test_random();
    test_rx_full();
    test_abort();
    test_rst_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
